zxbus_port_master: RTL and testbench
====================================

ZXBUS_PORT_MASTER -- requirements
Module: zxbus_port_master

Interface
REQ-001 SHALL have parameter STB_LEN, default 2: fclk cycles wrstb_n is held low per write (legal 1..7).
REQ-002 SHALL have ports (name direction width meaning):
- fclk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- zx_a  in  16  ZX bus address.
- zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n  in  1 each  ZX bus controls, asynchronous to fclk.
- zx_d_in  in  8  ZX bus data for writes.
- zx_d_out  out  8  data driven to ZX bus on reads.
- zx_d_oe  out  1  output enable for zx_d_out.
- iorqge  out  1  blocks other bus devices on port hit.
- wrstb_n  out  1  port-register write strobe; registers latch on its rising edge.
- wrena  out  1  write enable, qualifies wrstb_n.
- addr  out  2  port select: 11=#83AB, 10=#82AB, 01=#81AB.
- wrdata  out  8  write data to port registers.
- rddata  in  8  combinational read data from port registers for current addr.

Function
REQ-003 SHALL pass zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n through 2-flop synchronizers (reset value 1); the FSM SHALL use only stage-2 outputs.
REQ-004 Hit SHALL be zx_a[7:0]==8'hAB and zx_a[15:8] in {8'h81, 8'h82, 8'h83}; port #80AB is not a hit.
REQ-005 iorqge SHALL be combinational: 1 when hit and zx_m1_n==1 and zx_iorq_n==0; otherwise 0.
REQ-006 States SHALL be IDLE, WR_LOW, WR_RISE, RD_DRIVE, WAIT_END.
REQ-007 IDLE -> WR_LOW when synced iorq=0, wr=0, rd=1, m1=1 and hit.
- On this transition: latch addr<=zx_a[9:8] and wrdata<=zx_d_in; load strobe counter with STB_LEN-1.
REQ-008 IDLE -> RD_DRIVE when synced iorq=0, rd=0, wr=1, m1=1 and hit.
- On this transition: latch addr<=zx_a[9:8].
REQ-009 Synced rd and wr both low, m1 low, or no hit SHALL leave the FSM in IDLE, with no strobe and no drive.
REQ-010 WR_LOW SHALL drive wrstb_n=0, wrena=1.
- Counter decrements each cycle.
- At count 0 -> WR_RISE, so wrstb_n is low for exactly STB_LEN cycles.
REQ-011 WR_RISE SHALL drive wrstb_n=1, wrena=1 for exactly 1 cycle (enable held across the rising edge), then -> WAIT_END.
REQ-012 WAIT_END SHALL drive wrstb_n=1, wrena=0, zx_d_oe=0, and stay until synced iorq=1, then -> IDLE (one strobe per bus cycle).
REQ-013 A write cycle SHALL complete its full strobe sequence even if synced iorq rises during WR_LOW; WAIT_END then exits on the next cycle.
REQ-014 RD_DRIVE SHALL assert zx_d_oe=1 and register zx_d_out<=rddata every fclk.
- Exit -> IDLE on the first cycle synced iorq=1 or synced rd=1.
- zx_d_oe SHALL be 0 in that following cycle.
REQ-015 zx_d_oe SHALL be 1 only in RD_DRIVE; wrena SHALL be 1 only in WR_LOW/WR_RISE; wrstb_n SHALL be 0 only in WR_LOW.
REQ-016 addr, wrdata and zx_d_out SHALL hold their last values outside the states that update them.
REQ-017 Latency: inputs stable low before fclk edge N -> wrstb_n low (or zx_d_oe high) after edge N+2.
- Input setup then takes: sync1 at N, sync2 at N+1, FSM at N+2.

Reset
REQ-018 While rst_n=0, regardless of FSM state, the block SHALL hold:
- state=IDLE, wrstb_n=1, wrena=0, zx_d_oe=0;
- addr=2'b00, wrdata=8'h00, zx_d_out=8'h00;
- synchronizers=1, counter=0.
REQ-019 Reset asserted mid-write SHALL raise wrstb_n with wrena=0 in the same instant, so no register latch is qualified.
REQ-020 After rst_n rises, a bus cycle already in progress SHALL NOT be serviced until synced iorq has been seen high (WAIT_END entered on reset release).

Verification
REQ-021 Write #83AB, data 8'h54, STB_LEN=2 -> addr=11, wrdata=54 latched; wrstb_n low exactly 2 cycles starting 3 edges after iorq/wr fall; wrena=1 for 3 cycles; exactly one strobe.
REQ-022 Read #82AB, rddata=8'hA5 -> zx_d_oe=1 with zx_d_out=A5 from edge N+2; zx_d_oe=0 one cycle after synced rd rises; wrstb_n stays 1.
REQ-023 Access #80AB, #83AC, and an M1+IORQ (interrupt ack) at #83AB -> iorqge=0 for #80AB/#83AC, 0 for M1; no strobe, zx_d_oe stays 0 in all cases.
REQ-024 Write with iorq held low 20 cycles, then a second write to #81AB -> exactly one strobe per cycle; second write latches addr=01.
REQ-025 rst_n pulsed low during WR_LOW -> wrstb_n=1, wrena=0 immediately; after release with iorq still low, no strobe until iorq rises and a new cycle starts.
REQ-026 Simultaneous rd and wr low at #83AB -> FSM stays IDLE, zx_d_oe=0, wrstb_n=1.

Source files
------------

// File: rtl/zxbus_port_master.sv
// zxbus_port_master: decodes ZX bus I/O cycles to ports #81AB-#83AB and turns them into
// fclk-domain port-register write strobes and registered read data.
module zxbus_port_master #(
    parameter int STB_LEN = 2
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [15:0] zx_a,
    input  logic        zx_iorq_n,
    input  logic        zx_rd_n,
    input  logic        zx_wr_n,
    input  logic        zx_m1_n,
    input  logic [7:0]  zx_d_in,
    output logic [7:0]  zx_d_out,
    output logic        zx_d_oe,
    output logic        iorqge,
    output logic        wrstb_n,
    output logic        wrena,
    output logic [1:0]  addr,
    output logic [7:0]  wrdata,
    input  logic [7:0]  rddata
);
    typedef enum logic [2:0] {IDLE, WR_LOW, WR_RISE, RD_DRIVE, WAIT_END} state_t;
    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]  vld_q, vld_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wrdata_q, wrdata_d, zx_d_out_q, zx_d_out_d;
    logic        iorq_s, rd_s, wr_s, m1_s, hit;
    assign {iorq_s, rd_s, wr_s, m1_s} = sync2_q;
    assign hit = zx_a[7:0] == 8'hAB && zx_a[15:10] == 6'b100000 && zx_a[9:8] != 2'b00;
    assign iorqge = hit && zx_m1_n && !zx_iorq_n;
    // Strobe/enable decode straight from state so an async reset drops them at once.
    assign wrstb_n  = state_q != WR_LOW;
    assign wrena    = state_q == WR_LOW || state_q == WR_RISE;
    assign zx_d_oe  = state_q == RD_DRIVE;
    assign addr     = addr_q;
    assign wrdata   = wrdata_q;
    assign zx_d_out = zx_d_out_q;
    always_comb begin
        sync1_d    = {zx_iorq_n, zx_rd_n, zx_wr_n, zx_m1_n};
        sync2_d    = sync1_q;
        vld_d      = {vld_q[0], 1'b1};
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        zx_d_out_d = zx_d_out_q;
        case (state_q)
            // vld_q tracks whether the synchronizers hold real bus samples since reset release
            IDLE: if (!vld_q[0]) state_d = WAIT_END;
                  else if (!iorq_s && m1_s && hit && (rd_s ^ wr_s)) begin
                      addr_d = zx_a[9:8];
                      if (!wr_s) begin
                          state_d  = WR_LOW;
                          wrdata_d = zx_d_in;
                          cnt_d    = 3'(STB_LEN - 1);
                      end else begin
                          state_d    = RD_DRIVE;
                          zx_d_out_d = rddata;
                      end
                  end
            WR_LOW: if (cnt_q == 3'd0) state_d = WR_RISE; else cnt_d = cnt_q - 3'd1;
            WR_RISE: state_d = WAIT_END;
            RD_DRIVE: begin
                zx_d_out_d = rddata;
                state_d    = (iorq_s || rd_s) ? IDLE : RD_DRIVE;
            end
            WAIT_END: state_d = (iorq_s && vld_q[1]) ? IDLE : WAIT_END;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            vld_q      <= 2'b00;
            cnt_q      <= 3'd0;
            addr_q     <= 2'b00;
            wrdata_q   <= 8'h00;
            zx_d_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            zx_d_out_q <= zx_d_out_d;
        end
    end
endmodule

// File: tb/tb_zxbus_port_master.sv
// tb_zxbus_port_master: directed bus cycles; expected strobes/reads are queued and a
// negedge monitor checks each completed strobe or read drive against the queue.
module tb_zxbus_port_master;
    localparam int STB_LEN = 2;
    logic        fclk = 0, rst_n = 0;
    logic [15:0] zx_a = 16'h0000;
    logic        zx_iorq_n = 1, zx_rd_n = 1, zx_wr_n = 1, zx_m1_n = 1;
    logic [7:0]  zx_d_in = 8'h00, rddata = 8'h00;
    logic [7:0]  zx_d_out, wrdata;
    logic [1:0]  addr;
    logic        zx_d_oe, iorqge, wrstb_n, wrena;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] data;
        int         len;
        int         start;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    zxbus_port_master #(.STB_LEN(STB_LEN)) dut (
        .fclk(fclk), .rst_n(rst_n), .zx_a(zx_a), .zx_iorq_n(zx_iorq_n), .zx_rd_n(zx_rd_n),
        .zx_wr_n(zx_wr_n), .zx_m1_n(zx_m1_n), .zx_d_in(zx_d_in), .zx_d_out(zx_d_out),
        .zx_d_oe(zx_d_oe), .iorqge(iorqge), .wrstb_n(wrstb_n), .wrena(wrena),
        .addr(addr), .wrdata(wrdata), .rddata(rddata)
    );
    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask
    int lo_n = 0, en_n = 0, oe_n = 0, lo_start = 0, oe_start = 0;
    logic [7:0] oe_first = 8'h00;
    bit pw = 0, po = 0;
    always @(negedge fclk) begin
        if (!rst_n) begin
            lo_n = 0; en_n = 0; oe_n = 0; pw = 0; po = 0;
        end else begin
            if (!wrstb_n) begin
                if (lo_n == 0) lo_start = cyc;
                lo_n++;
            end
            if (wrena) en_n++;
            if (!wrstb_n && !wrena) check("strobe_without_enable", 0, 1);
            if (pw && !wrena) begin
                if (sb.size() == 0) check("unexpected_strobe", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("ev_is_write", 1, int'(e.wr));
                    check("wr_addr", addr, e.addr);
                    check("wr_data", wrdata, e.data);
                    check("wrstb_low_len", lo_n, e.len);
                    check("wrena_len", en_n, e.len + 1);
                    check("wrstb_start", lo_start, e.start);
                end
                lo_n = 0; en_n = 0;
            end
            if (zx_d_oe) begin
                if (oe_n == 0) begin oe_start = cyc; oe_first = zx_d_out; end
                oe_n++;
            end
            if (po && !zx_d_oe) begin
                if (sb.size() == 0) check("unexpected_read_drive", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("ev_is_read", 0, int'(e.wr));
                    check("rd_addr", addr, e.addr);
                    check("rd_data", oe_first, e.data);
                    check("rd_oe_len", oe_n, e.len);
                    check("rd_oe_start", oe_start, e.start);
                end
                oe_n = 0;
            end
            pw = wrena; po = zx_d_oe;
        end
    end
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                             input bit exp, input bit exp_ge);
        @(negedge fclk);
        zx_a = a; zx_d_in = d; zx_iorq_n = 0; zx_wr_n = 0;
        if (exp) sb.push_back('{1'b1, a[9:8], d, STB_LEN, cyc + 3});
        #1 check("iorqge_wr", iorqge, exp_ge);
        repeat (hold) @(negedge fclk);
        zx_iorq_n = 1; zx_wr_n = 1;
        repeat (6) @(negedge fclk);
    endtask
    task automatic bus_read(input logic [15:0] a, input int hold);
        @(negedge fclk);
        zx_a = a; zx_iorq_n = 0; zx_rd_n = 0;
        sb.push_back('{1'b0, a[9:8], rddata, hold, cyc + 3});
        #1 check("iorqge_rd", iorqge, 1);
        repeat (hold) @(negedge fclk);
        zx_iorq_n = 1; zx_rd_n = 1;
        repeat (6) @(negedge fclk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(negedge fclk);
        check("rst_wrstb_n", wrstb_n, 1);
        check("rst_wrena", wrena, 0);
        check("rst_oe", zx_d_oe, 0);
        check("rst_addr", addr, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_dout", zx_d_out, 0);
        rst_n = 1;
        repeat (6) @(negedge fclk);
        bus_write(16'h83AB, 8'h54, 6, 1, 1);
        rddata = 8'hA5;
        bus_read(16'h82AB, 5);
        check("dout_hold", zx_d_out, 8'hA5);
        bus_write(16'h80AB, 8'h99, 6, 0, 0);
        bus_write(16'h83AC, 8'h99, 6, 0, 0);
        @(negedge fclk);
        zx_a = 16'h83AB; zx_m1_n = 0; zx_iorq_n = 0;
        #1 check("iorqge_m1", iorqge, 0);
        repeat (5) @(negedge fclk);
        check("m1_no_oe", zx_d_oe, 0);
        zx_m1_n = 1; zx_iorq_n = 1;
        repeat (6) @(negedge fclk);
        bus_write(16'h83AB, 8'h11, 20, 1, 1);
        bus_write(16'h81AB, 8'hC3, 4, 1, 1);
        bus_write(16'h81AB, 8'h5A, 1, 1, 1);
        @(negedge fclk);
        zx_a = 16'h82AB; zx_d_in = 8'h77; zx_iorq_n = 0; zx_wr_n = 0;
        repeat (3) @(negedge fclk);
        check("mid_wrstb_low", wrstb_n, 0);
        #2 rst_n = 0;
        #1 check("mid_rst_wrstb_n", wrstb_n, 1);
        check("mid_rst_wrena", wrena, 0);
        check("mid_rst_wrdata", wrdata, 0);
        check("mid_rst_addr", addr, 0);
        repeat (2) @(negedge fclk);
        rst_n = 1;
        repeat (10) @(negedge fclk);
        check("post_rst_no_strobe", wrstb_n, 1);
        zx_iorq_n = 1; zx_wr_n = 1;
        repeat (6) @(negedge fclk);
        bus_write(16'h81AB, 8'h3C, 4, 1, 1);
        @(negedge fclk);
        zx_a = 16'h83AB; zx_iorq_n = 0; zx_rd_n = 0; zx_wr_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge fclk);
            check("rdwr_oe", zx_d_oe, 0);
            check("rdwr_wrstb_n", wrstb_n, 1);
        end
        zx_iorq_n = 1; zx_rd_n = 1; zx_wr_n = 1;
        repeat (10) @(negedge fclk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
